// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel prescaler, DrawX/DrawY scan counters,
// registered active-low syncs and visible-area flag, plus line/frame strobes.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pix_tick,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_end,
  output logic       frame_end
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] x_next;
  logic [CNT_W-1:0] y_next;
  logic             at_line_end;
  logic             at_frame_end;

  // Tick is suppressed during reset so no strobe can leak through a reset cycle.
  assign pix_tick     = ~Reset & (div_cnt == DIV_LAST);
  assign at_line_end  = (DrawX == H_LAST);
  assign at_frame_end = at_line_end & (DrawY == V_LAST);
  assign line_end     = pix_tick & at_line_end;
  assign frame_end    = pix_tick & at_frame_end;

  // Next scan position; syncs/blank are derived from it so they line up with DrawX/DrawY.
  always_comb begin
    x_next = DrawX;
    y_next = DrawY;
    if (pix_tick) begin
      if (at_line_end) begin
        x_next = '0;
        y_next = (DrawY == V_LAST) ? '0 : DrawY + CNT_W'(1);
      end else begin
        x_next = DrawX + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt <= '0;
      DrawX   <= '0;
      DrawY   <= '0;
      hs      <= 1'b1;
      vs      <= 1'b1;
      blank   <= 1'b1;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      DrawX   <= x_next;
      DrawY   <= y_next;
      hs      <= ~((x_next >= HS_FIRST) && (x_next <= HS_LAST));
      vs      <= ~((y_next >= VS_FIRST) && (y_next <= VS_LAST));
      blank   <= (x_next < H_VIS) && (y_next < V_VIS);
    end
  end

endmodule
